// File: rtl/warmup_pattern_checker_pkg.sv
// Shared types and constants for the warm-up pattern checker: lock states,
// pattern period and the expected code for each phase.
package warmup_pattern_checker_pkg;

  localparam int unsigned Period = 16;
  localparam int unsigned PhaseW = $clog2(Period);

  localparam logic [3:0] CodeZero = 4'd0;
  localparam logic [3:0] CodeOne  = 4'd1;
  localparam logic [3:0] CodeTwo  = 4'd2;

  typedef enum logic {
    StHunt,
    StLocked
  } state_e;

  // Phase 1 carries a 1, phase 2 carries a 2, every other phase is idle (0).
  function automatic logic [3:0] expected_code(input logic [PhaseW-1:0] phase);
    logic [3:0] code;
    code = CodeZero;
    if (phase == PhaseW'(1)) code = CodeOne;
    else if (phase == PhaseW'(2)) code = CodeTwo;
    return code;
  endfunction

endpackage

// File: rtl/warmup_pattern_checker_if.sv
// Sample input and status output bundle of the warm-up pattern checker.
interface warmup_pattern_checker_if #(
  parameter int unsigned ERR_W = 8
);

  logic             code_valid;
  logic [3:0]       code_in;
  logic             locked;
  logic             mismatch;
  logic [ERR_W-1:0] err_count;
  logic [3:0]       phase;

  modport master (
    output code_valid,
    output code_in,
    input  locked,
    input  mismatch,
    input  err_count,
    input  phase
  );

  modport slave (
    input  code_valid,
    input  code_in,
    output locked,
    output mismatch,
    output err_count,
    output phase
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear wins.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/warmup_pattern_checker.sv
// Hunts for the 1-then-2 marker of a 16-sample pattern, then tracks phase and
// flags mismatching samples; too many consecutive misses drop back to hunting.
module warmup_pattern_checker
  import warmup_pattern_checker_pkg::*;
#(
  parameter int unsigned MISS_LIMIT = 3,
  parameter int unsigned ERR_W      = 8
) (
  input logic                     clk,
  input logic                     rst,
  warmup_pattern_checker_if.slave bus
);

  localparam logic [3:0] MissLimit = 4'(MISS_LIMIT);

  state_e            r_state, w_state_nxt;
  logic [PhaseW-1:0] r_phase, w_phase_nxt, w_phase_inc;
  logic [3:0]        r_prev, w_prev_nxt;
  logic [3:0]        r_miss, w_miss_nxt;
  logic              r_mismatch, w_mismatch_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StHunt;
      r_phase    <= '0;
      r_prev     <= '0;
      r_miss     <= '0;
      r_mismatch <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_prev     <= w_prev_nxt;
      r_miss     <= w_miss_nxt;
      r_mismatch <= w_mismatch_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_phase_nxt    = r_phase;
    w_prev_nxt     = r_prev;
    w_miss_nxt     = r_miss;
    w_mismatch_nxt = 1'b0;
    w_phase_inc    = r_phase + PhaseW'(1);

    if (bus.code_valid) begin
      w_prev_nxt = bus.code_in;
      unique case (r_state)
        StHunt: begin
          if ((bus.code_in == CodeTwo) && (r_prev == CodeOne)) begin
            w_state_nxt = StLocked;
            w_phase_nxt = PhaseW'(2);
            w_miss_nxt  = '0;
          end
        end
        StLocked: begin
          w_phase_nxt = w_phase_inc;
          // Codes above 2 never equal an expected code, so they always miss.
          if (bus.code_in != expected_code(w_phase_inc)) begin
            w_mismatch_nxt = 1'b1;
            if ((r_miss + 4'd1) >= MissLimit) begin
              w_state_nxt = StHunt;
              w_phase_nxt = '0;
              w_miss_nxt  = '0;
            end else begin
              w_miss_nxt = r_miss + 4'd1;
            end
          end else begin
            w_miss_nxt = '0;
          end
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH (ERR_W)
  ) u_err_count (
    .clk     (clk),
    .i_inc   (w_mismatch_nxt),
    .i_clr   (rst),
    .o_count (bus.err_count)
  );

  assign bus.locked   = (r_state == StLocked);
  assign bus.phase    = r_phase;
  assign bus.mismatch = r_mismatch;

endmodule

// File: tb/tb_warmup_pattern_checker.sv
// Directed bench for warmup_pattern_checker: one default instance and one with
// a 2-bit error counter for the saturation case.
module tb_warmup_pattern_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  warmup_pattern_checker_if #(.ERR_W(8)) bus_a ();
  warmup_pattern_checker_if #(.ERR_W(2)) bus_b ();

  warmup_pattern_checker #(
    .MISS_LIMIT (3),
    .ERR_W      (8)
  ) u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a.slave)
  );

  warmup_pattern_checker #(
    .MISS_LIMIT (3),
    .ERR_W      (2)
  ) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b.slave)
  );

  // {locked, mismatch, phase, err_count}
  wire [13:0] obs_a = {bus_a.locked, bus_a.mismatch, bus_a.phase, bus_a.err_count};
  wire [7:0]  obs_b = {bus_b.locked, bus_b.mismatch, bus_b.phase, bus_b.err_count};

  int checks = 0;
  int errors = 0;
  logic [13:0] exp_a;
  logic [7:0]  exp_b;

  task automatic send_a(input logic v, input logic [3:0] c);
    bus_a.code_valid = v;
    bus_a.code_in    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_b(input logic v, input logic [3:0] c);
    bus_b.code_valid = v;
    bus_b.code_in    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_a = 1'b1;
    send_a(1'b1, 4'd2);
    exp_a = {1'b0, 1'b0, 4'd0, 8'd0};
    checks++;
    if (obs_a !== exp_a) begin
      errors++;
      $display("FAIL reset_state got %h want %h", obs_a, exp_a);
    end
    rst_a = 1'b0;
    send_a(1'b1, 4'd1);
    rst_a = 1'b1;
    send_a(1'b0, 4'd0);
    rst_a = 1'b0;
    // Reset must have cleared the remembered 1, so this 2 cannot lock.
    send_a(1'b1, 4'd2);
    checks++;
    if (obs_a !== exp_a) begin
      errors++;
      $display("FAIL reset_clears_prev got %h want %h", obs_a, exp_a);
    end
  endtask

  task automatic test_lock_run;
    send_a(1'b1, 4'd0);
    send_a(1'b1, 4'd1);
    exp_a = {1'b0, 1'b0, 4'd0, 8'd0};
    checks++;
    if (obs_a !== exp_a) begin
      errors++;
      $display("FAIL hunt_before_lock got %h want %h", obs_a, exp_a);
    end
    send_a(1'b1, 4'd2);
    exp_a = {1'b1, 1'b0, 4'd2, 8'd0};
    checks++;
    if (obs_a !== exp_a) begin
      errors++;
      $display("FAIL lock got %h want %h", obs_a, exp_a);
    end
    for (int i = 0; i < 14; i++) begin
      send_a(1'b1, 4'd0);
      exp_a = {1'b1, 1'b0, 4'(3 + i), 8'd0};
      checks++;
      if (obs_a !== exp_a) begin
        errors++;
        $display("FAIL run_phase%0d got %h want %h", i, obs_a, exp_a);
      end
    end
    send_a(1'b1, 4'd1);
    send_a(1'b1, 4'd2);
    exp_a = {1'b1, 1'b0, 4'd2, 8'd0};
    checks++;
    if (obs_a !== exp_a) begin
      errors++;
      $display("FAIL wrap_to_2 got %h want %h", obs_a, exp_a);
    end
  endtask

  task automatic test_single_error;
    send_a(1'b1, 4'd0);
    send_a(1'b1, 4'd0);
    send_a(1'b1, 4'd0);
    send_a(1'b1, 4'd1);
    exp_a = {1'b1, 1'b1, 4'd6, 8'd1};
    checks++;
    if (obs_a !== exp_a) begin
      errors++;
      $display("FAIL single_err got %h want %h", obs_a, exp_a);
    end
    send_a(1'b1, 4'd0);
    exp_a = {1'b1, 1'b0, 4'd7, 8'd1};
    checks++;
    if (obs_a !== exp_a) begin
      errors++;
      $display("FAIL pulse_one_cycle got %h want %h", obs_a, exp_a);
    end
    // Two more misses stay locked only if the earlier match cleared the count.
    send_a(1'b1, 4'd5);
    send_a(1'b1, 4'd5);
    exp_a = {1'b1, 1'b1, 4'd9, 8'd3};
    checks++;
    if (obs_a !== exp_a) begin
      errors++;
      $display("FAIL miss_cleared got %h want %h", obs_a, exp_a);
    end
    send_a(1'b1, 4'd0);
  endtask

  task automatic test_loss_of_lock;
    logic [13:0] exp_seq [3];
    exp_seq = '{{1'b1, 1'b1, 4'd11, 8'd4}, {1'b1, 1'b1, 4'd12, 8'd5},
                {1'b0, 1'b1, 4'd0, 8'd6}};
    send_a(1'b1, 4'd7);
    checks++;
    if (obs_a !== exp_seq[0]) begin
      errors++;
      $display("FAIL loss_miss1 got %h want %h", obs_a, exp_seq[0]);
    end
    send_a(1'b1, 4'd7);
    checks++;
    if (obs_a !== exp_seq[1]) begin
      errors++;
      $display("FAIL loss_miss2 got %h want %h", obs_a, exp_seq[1]);
    end
    send_a(1'b1, 4'd1);
    checks++;
    if (obs_a !== exp_seq[2]) begin
      errors++;
      $display("FAIL loss_drop got %h want %h", obs_a, exp_seq[2]);
    end
    send_a(1'b0, 4'd0);
    exp_a = {1'b0, 1'b0, 4'd0, 8'd6};
    checks++;
    if (obs_a !== exp_a) begin
      errors++;
      $display("FAIL loss_idle got %h want %h", obs_a, exp_a);
    end
    // The failing 1 serves as the first half of the re-lock pair.
    send_a(1'b1, 4'd2);
    exp_a = {1'b1, 1'b0, 4'd2, 8'd6};
    checks++;
    if (obs_a !== exp_a) begin
      errors++;
      $display("FAIL relock_from_fail got %h want %h", obs_a, exp_a);
    end
    send_a(1'b1, 4'd9);
    send_a(1'b1, 4'd9);
    send_a(1'b1, 4'd9);
    send_a(1'b1, 4'd2);
    exp_a = {1'b0, 1'b0, 4'd0, 8'd9};
    checks++;
    if (obs_a !== exp_a) begin
      errors++;
      $display("FAIL hunt_no_pulse got %h want %h", obs_a, exp_a);
    end
    send_a(1'b1, 4'd1);
    send_a(1'b1, 4'd2);
    exp_a = {1'b1, 1'b0, 4'd2, 8'd9};
    checks++;
    if (obs_a !== exp_a) begin
      errors++;
      $display("FAIL relock got %h want %h", obs_a, exp_a);
    end
  endtask

  task automatic test_gaps;
    send_a(1'b0, 4'd9);
    send_a(1'b0, 4'd9);
    exp_a = {1'b1, 1'b0, 4'd2, 8'd9};
    checks++;
    if (obs_a !== exp_a) begin
      errors++;
      $display("FAIL gap_hold got %h want %h", obs_a, exp_a);
    end
    send_a(1'b1, 4'd0);
    send_a(1'b0, 4'd1);
    exp_a = {1'b1, 1'b0, 4'd3, 8'd9};
    checks++;
    if (obs_a !== exp_a) begin
      errors++;
      $display("FAIL gap_hold2 got %h want %h", obs_a, exp_a);
    end
    send_a(1'b1, 4'd0);
    send_a(1'b0, 4'd0);
    exp_a = {1'b1, 1'b0, 4'd4, 8'd9};
    checks++;
    if (obs_a !== exp_a) begin
      errors++;
      $display("FAIL gap_advance got %h want %h", obs_a, exp_a);
    end
  endtask

  task automatic test_reset_mid;
    rst_a = 1'b1;
    send_a(1'b1, 4'd7);
    rst_a = 1'b0;
    exp_a = {1'b0, 1'b0, 4'd0, 8'd0};
    checks++;
    if (obs_a !== exp_a) begin
      errors++;
      $display("FAIL reset_mid got %h want %h", obs_a, exp_a);
    end
    send_a(1'b0, 4'd0);
    checks++;
    if (obs_a !== exp_a) begin
      errors++;
      $display("FAIL reset_mid_after got %h want %h", obs_a, exp_a);
    end
  endtask

  task automatic test_saturation;
    logic [1:0] sat_exp [5];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst_b = 1'b0;
    send_b(1'b1, 4'd1);
    send_b(1'b1, 4'd2);
    exp_b = {1'b1, 1'b0, 4'd2, 2'd0};
    checks++;
    if (obs_b !== exp_b) begin
      errors++;
      $display("FAIL sat_lock got %h want %h", obs_b, exp_b);
    end
    for (int k = 0; k < 5; k++) begin
      send_b(1'b1, 4'd9);
      exp_b = {1'b1, 1'b1, 4'(3 + 2 * k), sat_exp[k]};
      checks++;
      if (obs_b !== exp_b) begin
        errors++;
        $display("FAIL sat_err%0d got %h want %h", k, obs_b, exp_b);
      end
      send_b(1'b1, 4'd0);
      exp_b = {1'b1, 1'b0, 4'(4 + 2 * k), sat_exp[k]};
      checks++;
      if (obs_b !== exp_b) begin
        errors++;
        $display("FAIL sat_ok%0d got %h want %h", k, obs_b, exp_b);
      end
    end
    send_b(1'b0, 4'd0);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.code_valid = 1'b0;
    bus_a.code_in    = 4'd0;
    bus_b.code_valid = 1'b0;
    bus_b.code_in    = 4'd0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    test_reset();
    test_lock_run();
    test_single_error();
    test_loss_of_lock();
    test_gaps();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
